// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcodes and the fetch-stage state/entry types.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDIU = 6'h09,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam word_t PC_INCR = 32'd4;

    // One fetched instruction with its fall-through address and prediction tag.
    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  taken;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is stalled.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_load,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);
    logic         r_valid;
    fetch_entry_t r_entry;

    // Clear wins: a flush or drain in the same cycle must not leave a stale entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache read port and fills
// the fetch/decode latch through a one-entry hold buffer.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         nRST,
    output logic         imemREN,
    output word_t        imemaddr,
    input  logic         ihit,
    input  word_t        imemload,
    input  logic         stall,
    input  logic         squash,
    input  logic         halt,
    input  logic         misc_npc_en,
    input  word_t        misc_npc,
    input  logic         cancel_fetch,
    input  logic         pred_taken,
    output word_t        npc_default,
    output logic         npc_valid,
    output logic         fd_valid,
    output word_t        fd_instruction,
    output word_t        fd_instr_npc,
    output logic         fd_branch_taken,
    output fetch_state_t o_dbg_state,
    output logic         o_dbg_hold_valid
);
    fetch_state_t r_state;
    word_t        r_pc;
    logic         r_fd_valid;
    word_t        r_fd_instr;
    word_t        r_fd_npc;
    logic         r_fd_taken;

    word_t        w_pc_plus4;
    word_t        w_pc_next;
    logic         w_fetch_done;
    logic         w_accept;
    logic         w_hold_valid;
    logic         w_hold_load;
    logic         w_hold_clear;
    fetch_entry_t w_hold_entry;
    fetch_entry_t w_new_entry;

    assign w_pc_plus4   = r_pc + PC_INCR;
    // nRST gates the request so an outstanding read is abandoned during reset.
    assign imemREN      = nRST && (r_state == RUN) && !w_hold_valid;
    assign w_fetch_done = imemREN && ihit;
    assign w_accept     = w_fetch_done && !cancel_fetch;
    assign w_new_entry  = '{instr: imemload, npc: w_pc_plus4, taken: pred_taken};

    assign w_hold_load  = stall && w_accept;
    assign w_hold_clear = squash || cancel_fetch || (!stall && w_hold_valid);

    fetch_hold_buf u_hold (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_entry (w_new_entry),
        .o_valid (w_hold_valid),
        .o_entry (w_hold_entry)
    );

    // Next PC: wrong-path cancel, then taken redirect, then fall-through.
    always_comb begin
        w_pc_next = r_pc;
        if (r_state == RUN) begin
            if (cancel_fetch) begin
                w_pc_next = misc_npc;
            end else if (misc_npc_en && w_fetch_done) begin
                w_pc_next = misc_npc;
            end else if (w_fetch_done) begin
                w_pc_next = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_fd_valid <= 1'b0;
            r_fd_instr <= '0;
            r_fd_npc   <= '0;
            r_fd_taken <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                RUN:     if (halt) r_state <= HALTED;
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase

            if (squash) begin
                r_fd_valid <= 1'b0;
            end else if (!stall) begin
                if (w_hold_valid) begin
                    r_fd_valid <= 1'b1;
                    r_fd_instr <= w_hold_entry.instr;
                    r_fd_npc   <= w_hold_entry.npc;
                    r_fd_taken <= w_hold_entry.taken;
                end else if (w_accept) begin
                    r_fd_valid <= 1'b1;
                    r_fd_instr <= w_new_entry.instr;
                    r_fd_npc   <= w_new_entry.npc;
                    r_fd_taken <= w_new_entry.taken;
                end else begin
                    r_fd_valid <= 1'b0;
                end
            end
        end
    end

    assign imemaddr         = r_pc;
    assign npc_default      = w_pc_plus4;
    assign npc_valid        = w_fetch_done;
    assign fd_valid         = r_fd_valid;
    assign fd_instruction   = r_fd_instr;
    assign fd_instr_npc     = r_fd_npc;
    assign fd_branch_taken  = r_fd_taken;
    assign o_dbg_state      = r_state;
    assign o_dbg_hold_valid = w_hold_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based fetch model checked every cycle,
// plus literal checkpoints along the test-plan scenarios.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic         CLK;
    logic         nRST;
    logic         imemREN;
    word_t        imemaddr;
    logic         ihit;
    word_t        imemload;
    logic         stall;
    logic         squash;
    logic         halt;
    logic         misc_npc_en;
    word_t        misc_npc;
    logic         cancel_fetch;
    logic         pred_taken;
    word_t        npc_default;
    logic         npc_valid;
    logic         fd_valid;
    word_t        fd_instruction;
    word_t        fd_instr_npc;
    logic         fd_branch_taken;
    fetch_state_t o_dbg_state;
    logic         o_dbg_hold_valid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .imemREN          (imemREN),
        .imemaddr         (imemaddr),
        .ihit             (ihit),
        .imemload         (imemload),
        .stall            (stall),
        .squash           (squash),
        .halt             (halt),
        .misc_npc_en      (misc_npc_en),
        .misc_npc         (misc_npc),
        .cancel_fetch     (cancel_fetch),
        .pred_taken       (pred_taken),
        .npc_default      (npc_default),
        .npc_valid        (npc_valid),
        .fd_valid         (fd_valid),
        .fd_instruction   (fd_instruction),
        .fd_instr_npc     (fd_instr_npc),
        .fd_branch_taken  (fd_branch_taken),
        .o_dbg_state      (o_dbg_state),
        .o_dbg_hold_valid (o_dbg_hold_valid)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Icache contents: every word is tagged with its own address.
    function automatic word_t mem_word(input word_t a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // ---------------- behavioural model ----------------
    logic         m_halted;
    word_t        m_pc;
    logic         m_fd_valid;
    word_t        m_fd_instr;
    word_t        m_fd_npc;
    logic         m_fd_taken;
    logic [64:0]  exp_q[$];   // parked fetch {instr, npc, taken}

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_halted   = 1'b0;
            m_pc       = 32'h0;
            m_fd_valid = 1'b0;
            m_fd_instr = 32'h0;
            m_fd_npc   = 32'h0;
            m_fd_taken = 1'b0;
            exp_q.delete();
        end else begin : model_step
            logic        fetching;
            logic        done;
            logic        keep;
            logic [64:0] ent;
            word_t       pc_n;
            fetching = !m_halted && (exp_q.size() == 0);
            done     = fetching && ihit;
            keep     = done && !cancel_fetch;
            ent      = {mem_word(m_pc), m_pc + 32'd4, pred_taken};
            pc_n     = m_pc;
            if (!m_halted) begin
                if (cancel_fetch)             pc_n = misc_npc;
                else if (misc_npc_en && done) pc_n = misc_npc;
                else if (done)                pc_n = m_pc + 32'd4;
            end
            if (squash) begin
                m_fd_valid = 1'b0;
                exp_q.delete();
            end else if (!stall) begin
                if (exp_q.size() != 0) begin
                    ent = exp_q.pop_front();
                    {m_fd_instr, m_fd_npc, m_fd_taken} = ent;
                    m_fd_valid = 1'b1;
                end else if (keep) begin
                    {m_fd_instr, m_fd_npc, m_fd_taken} = ent;
                    m_fd_valid = 1'b1;
                end else begin
                    m_fd_valid = 1'b0;
                end
            end else if (keep) begin
                exp_q.push_back(ent);
            end
            if (cancel_fetch) exp_q.delete();
            if (halt) m_halted = 1'b1;
            m_pc = pc_n;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin : compare
        logic e_ren;
        e_ren = nRST && !m_halted && (exp_q.size() == 0);
        check("imemREN",     {31'b0, imemREN},          {31'b0, e_ren});
        check("imemaddr",    imemaddr,                  m_pc);
        check("npc_default", npc_default,               m_pc + 32'd4);
        check("npc_valid",   {31'b0, npc_valid},        {31'b0, e_ren && ihit});
        check("fd_valid",    {31'b0, fd_valid},         {31'b0, m_fd_valid});
        check("fd_instr",    fd_instruction,            m_fd_instr);
        check("fd_npc",      fd_instr_npc,              m_fd_npc);
        check("fd_taken",    {31'b0, fd_branch_taken},  {31'b0, m_fd_taken});
        check("hold_valid",  {31'b0, o_dbg_hold_valid}, {31'b0, exp_q.size() != 0});
        check("state",       {31'b0, o_dbg_state == HALTED}, {31'b0, m_halted});
    end

    // ---------------- driver ----------------
    // Apply one cycle of inputs, then return #1 after the edge that consumes them.
    task automatic step(input logic hit, input logic stl, input logic sq, input logic hlt,
                        input logic en, input word_t tgt, input logic cnc, input logic tk);
        ihit         = hit;
        stall        = stl;
        squash       = sq;
        halt         = hlt;
        misc_npc_en  = en;
        misc_npc     = tgt;
        cancel_fetch = cnc;
        pred_taken   = tk;
        imemload     = mem_word(imemaddr);
        @(posedge CLK);
        #1;
        imemload = mem_word(imemaddr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        nRST = 1'b0;
        step(0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("rst_pc",   imemaddr, 32'h0);
        check("rst_ren",  {31'b0, imemREN},  32'h0);
        check("rst_fdv",  {31'b0, fd_valid}, 32'h0);
        check("rst_fdn",  fd_instr_npc, 32'h0);
        nRST = 1'b1;

        // Straight-line fetch
        run(1);
        check("seq_fdv", {31'b0, fd_valid}, 32'h1);
        check("seq_npc1", fd_instr_npc, 32'h4);
        check("seq_pc1", imemaddr, 32'h4);
        run(3);
        check("seq_pc4", imemaddr, 32'h10);
        check("seq_ins", fd_instruction, 32'hC0DE_000C);

        // icache miss bubbles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 0);
        check("miss_pc", imemaddr, 32'h10);
        check("miss_fdv", {31'b0, fd_valid}, 32'h0);
        run(1);
        check("miss_npc", fd_instr_npc, 32'h14);
        run(3);

        // Stall with hit at 0x20
        step(1, 1, 0, 0, 0, 32'h0, 0, 0);
        check("stl_pc", imemaddr, 32'h24);
        check("stl_hold", {31'b0, o_dbg_hold_valid}, 32'h1);
        check("stl_ren", {31'b0, imemREN}, 32'h0);
        check("stl_npc", fd_instr_npc, 32'h20);
        step(1, 1, 0, 0, 0, 32'h0, 0, 0);
        check("stl2_pc", imemaddr, 32'h24);
        step(1, 0, 0, 0, 0, 32'h0, 0, 0);
        check("rel_npc", fd_instr_npc, 32'h24);
        check("rel_hold", {31'b0, o_dbg_hold_valid}, 32'h0);
        check("rel_pc", imemaddr, 32'h24);
        run(7);
        check("pre_br_pc", imemaddr, 32'h40);

        // Predicted-taken redirect
        step(1, 0, 0, 0, 1, 32'h100, 0, 1);
        check("br_taken", {31'b0, fd_branch_taken}, 32'h1);
        check("br_npc", fd_instr_npc, 32'h44);
        check("br_pc", imemaddr, 32'h100);
        run(1);
        check("br_after", fd_instr_npc, 32'h104);

        // Squash while holding
        step(1, 1, 0, 0, 0, 32'h0, 0, 0);
        check("sq_hold", {31'b0, o_dbg_hold_valid}, 32'h1);
        step(1, 1, 1, 0, 0, 32'h80, 1, 0);
        check("sq_fdv", {31'b0, fd_valid}, 32'h0);
        check("sq_hold0", {31'b0, o_dbg_hold_valid}, 32'h0);
        check("sq_pc", imemaddr, 32'h80);

        // Redirect without hit is ignored; cancel drops a completing fetch
        step(0, 0, 0, 0, 1, 32'h200, 0, 0);
        check("en_nohit", imemaddr, 32'h80);
        step(1, 0, 0, 0, 0, 32'h60, 1, 0);
        check("cnc_pc", imemaddr, 32'h60);
        check("cnc_fdv", {31'b0, fd_valid}, 32'h0);

        // PC wrap
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        check("wrap_def", npc_default, 32'h0);
        run(1);
        check("wrap_npc", fd_instr_npc, 32'h0);
        check("wrap_pc", imemaddr, 32'h0);

        // Halt
        step(1, 0, 0, 0, 1, 32'h60, 0, 0);
        step(0, 0, 0, 1, 0, 32'h0, 0, 0);
        check("hlt_ren", {31'b0, imemREN}, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 32'h300, 1, 0);
        check("hlt_pc", imemaddr, 32'h60);
        check("hlt_st", {31'b0, o_dbg_state == HALTED}, 32'h1);

        // Asynchronous reset mid-cycle
        #2;
        nRST = 1'b0;
        #1;
        check("arst_pc", imemaddr, 32'h0);
        check("arst_ren", {31'b0, imemREN}, 32'h0);
        check("arst_st", {31'b0, o_dbg_state == HALTED}, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        run(2);
        check("post_pc", imemaddr, 32'h8);
        check("post_npc", fd_instr_npc, 32'h8);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
